operand_read_stage: RTL and testbench

//  Decode-side reader of the register file: accepts fetched RV32I instructions over valid/ready,

---
 rtl/operand_read_stage_pkg.sv | 42 ++++
 rtl/operand_read_stage_if.sv | 35 +++
 rtl/operand_read_stage_operand_use.sv | 37 +++
 rtl/operand_read_stage.sv | 111 +++++++++++
 tb/tb_operand_read_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_read_stage_pkg.sv
// Shared definitions for the operand-read stage: RV32I opcodes, instruction field
// positions, datapath widths and field-extraction helpers.
package operand_read_stage_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int ILEN   = 32;
  localparam int REG_AW = 5;

  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;
  typedef logic [ILEN-1:0]   instr_t;

  function automatic reg_idx_t f_rs1(input instr_t instr);
    return instr[RS1_LSB +: REG_AW];
  endfunction

  function automatic reg_idx_t f_rs2(input instr_t instr);
    return instr[RS2_LSB +: REG_AW];
  endfunction

  function automatic reg_idx_t f_rd(input instr_t instr);
    return instr[RD_LSB +: REG_AW];
  endfunction

endpackage

// File: rtl/operand_read_stage_if.sv
// Bundle of fetch, regfile, writeback and execute-side signals seen by the operand-read stage.
interface operand_read_stage_if;
  import operand_read_stage_pkg::*;

  logic     in_valid;
  logic     in_ready;
  instr_t   in_instr;
  reg_idx_t rf_rs1;
  reg_idx_t rf_rs2;
  xword_t   rf_op1;
  xword_t   rf_op2;
  logic     wb_valid;
  reg_idx_t wb_rd;
  xword_t   wb_data;
  logic     flush;
  logic     out_valid;
  logic     out_ready;
  instr_t   out_instr;
  xword_t   out_op1;
  xword_t   out_op2;
  reg_idx_t out_rd;

  // The stage itself
  modport slave (
    input  in_valid, in_instr, rf_op1, rf_op2, wb_valid, wb_rd, wb_data, flush, out_ready,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_instr, out_op1, out_op2, out_rd
  );

  // Surrounding pipeline: fetch, regfile, writeback and execute
  modport master (
    output in_valid, in_instr, rf_op1, rf_op2, wb_valid, wb_rd, wb_data, flush, out_ready,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_instr, out_op1, out_op2, out_rd
  );

endinterface

// File: rtl/operand_read_stage_operand_use.sv
// Combinational RV32I opcode classifier: which of rs1/rs2/rd an instruction actually uses.
module rv32i_operand_use
  import operand_read_stage_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             use_rs1,
  output logic             use_rs2,
  output logic             use_rd
);

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    unique case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        use_rd = 1'b1;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      // FENCE, SYSTEM and unknown encodings touch no registers
      default: ;
    endcase
  end

endmodule

// File: rtl/operand_read_stage.sv
// Operand-read stage: reads rs1/rs2 from the regfile (with writeback bypass), stalls on
// RAW/WAW hazards against a busy scoreboard, and holds one instruction for execute.
module operand_read_stage
  import operand_read_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  operand_read_stage_if.slave  bus
);

  logic            use_rs1;
  logic            use_rs2;
  logic            use_rd;
  reg_idx_t        rs1;
  reg_idx_t        rs2;
  reg_idx_t        rd_eff;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] busy_p0;
  logic            hazard;
  logic            in_ready;
  logic            accept;
  xword_t          op1_sel;
  xword_t          op2_sel;

  logic            vld_p0;
  instr_t          instr_p0;
  xword_t          op1_p0;
  xword_t          op2_p0;
  reg_idx_t        rd_p0;

  // A writeback landing this cycle is not yet visible in the regfile, so forward it.
  function automatic xword_t f_sel_operand(input logic used, input reg_idx_t rs,
                                           input xword_t rf_data, input logic wb_valid,
                                           input reg_idx_t wb_rd, input xword_t wb_data);
    if (!used)
      return '0;
    if (wb_valid && (wb_rd == rs) && (rs != '0))
      return wb_data;
    return rf_data;
  endfunction

  rv32i_operand_use u_operand_use (
    .opcode  (bus.in_instr[OPC_LSB +: OPC_W]),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .use_rd  (use_rd)
  );

  assign rs1        = f_rs1(bus.in_instr);
  assign rs2        = f_rs2(bus.in_instr);
  assign rd_eff     = use_rd ? f_rd(bus.in_instr) : '0;
  assign bus.rf_rs1 = rs1;
  assign bus.rf_rs2 = rs2;

  assign wb_mask  = bus.wb_valid ? ({{(NREG-1){1'b0}}, 1'b1} << bus.wb_rd) : '0;
  assign busy_eff = busy_p0 & ~wb_mask;

  assign hazard   = (use_rs1 & busy_eff[rs1]) |
                    (use_rs2 & busy_eff[rs2]) |
                    ((rd_eff != '0) & busy_eff[rd_eff]);
  assign in_ready = ~hazard & (~vld_p0 | bus.out_ready) & ~bus.flush;
  assign accept   = bus.in_valid & in_ready;

  assign op1_sel = f_sel_operand(use_rs1, rs1, bus.rf_op1, bus.wb_valid, bus.wb_rd, bus.wb_data);
  assign op2_sel = f_sel_operand(use_rs2, rs2, bus.rf_op2, bus.wb_valid, bus.wb_rd, bus.wb_data);

  // Clears first, then the new destination, so a same-cycle set beats a clear.
  always_comb begin
    busy_nxt = busy_p0 & ~wb_mask;
    if (bus.flush && vld_p0)
      busy_nxt[rd_p0] = 1'b0;
    if (accept && (rd_eff != '0))
      busy_nxt[rd_eff] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // ---- stage p0: execute-side holding register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      busy_p0  <= '0;
      instr_p0 <= '0;
      op1_p0   <= '0;
      op2_p0   <= '0;
      rd_p0    <= '0;
    end else begin
      busy_p0 <= busy_nxt;
      if (bus.flush) begin
        vld_p0 <= 1'b0;
      end else if (accept) begin
        vld_p0   <= 1'b1;
        instr_p0 <= bus.in_instr;
        op1_p0   <= op1_sel;
        op2_p0   <= op2_sel;
        rd_p0    <= rd_eff;
      end else if (bus.out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p0;
  assign bus.out_instr = instr_p0;
  assign bus.out_op1   = op1_p0;
  assign bus.out_op2   = op2_p0;
  assign bus.out_rd    = rd_p0;

endmodule

// File: tb/tb_operand_read_stage.sv
// Scoreboard bench for operand_read_stage: directed hazard/bypass/flush/reset scenarios,
// then randomized traffic checked against a register-level reference model.
module tb_operand_read_stage;
  import operand_read_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_read_stage_if bus ();

  operand_read_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Regfile: writes land at the clock edge, reads are combinational.
  xword_t regs [NREG];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.wb_valid && (bus.wb_rd != '0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end
  assign bus.rf_op1 = regs[bus.rf_rs1];
  assign bus.rf_op2 = regs[bus.rf_rs2];

  typedef struct packed {
    instr_t   instr;
    xword_t   op1;
    xword_t   op2;
    reg_idx_t rd;
  } txn_t;

  txn_t            exp_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [NREG-1:0] m_busy  = '0;
  logic            m_out_valid = 1'b0;
  reg_idx_t        m_out_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register usage by opcode: {rs1, rs2, rd}
  function automatic logic [2:0] m_uses(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL:    return 3'b001;
      OPC_JALR, OPC_LOAD, OPC_OPIMM:  return 3'b101;
      OPC_BRANCH, OPC_STORE:          return 3'b110;
      OPC_OP:                         return 3'b111;
      default:                        return 3'b000;
    endcase
  endfunction

  function automatic instr_t enc_r(input logic [6:0] opc, input reg_idx_t rd,
                                   input reg_idx_t rs1, input reg_idx_t rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, opc};
  endfunction

  function automatic instr_t enc_i(input logic [6:0] opc, input reg_idx_t rd,
                                   input reg_idx_t rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, opc};
  endfunction

  // One clock cycle: drive, check combinational outputs against the model, advance the model.
  task automatic step(input bit iv, input instr_t ins, input bit ordy, input bit wv,
                      input reg_idx_t wr, input xword_t wd, input bit fl);
    logic [2:0] u;
    reg_idx_t   rs1, rs2, rd;
    logic       haz, exp_rdy, acc;
    txn_t       t;
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.wb_valid  = wv;
    bus.wb_rd     = wr;
    bus.wb_data   = wd;
    bus.flush     = fl;
    #1;
    u   = m_uses(ins[6:0]);
    rs1 = ins[19:15];
    rs2 = ins[24:20];
    rd  = u[0] ? ins[11:7] : 5'd0;
    haz = (u[2] && m_busy[rs1] && !(wv && wr == rs1)) ||
          (u[1] && m_busy[rs2] && !(wv && wr == rs2)) ||
          (rd != 0 && m_busy[rd] && !(wv && wr == rd));
    exp_rdy = !haz && (!m_out_valid || ordy) && !fl;
    check("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    check("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
    check("rf_rs1",    32'(bus.rf_rs1),    32'(rs1));
    check("rf_rs2",    32'(bus.rf_rs2),    32'(rs2));
    acc = iv && exp_rdy;
    if (acc) begin
      t.instr = ins;
      t.op1   = !u[2] ? '0 : (wv && wr == rs1 && rs1 != 0) ? wd : regs[rs1];
      t.op2   = !u[1] ? '0 : (wv && wr == rs2 && rs2 != 0) ? wd : regs[rs2];
      t.rd    = rd;
      exp_q.push_back(t);
    end
    if (wv) m_busy[wr] = 1'b0;
    if (fl && m_out_valid) m_busy[m_out_rd] = 1'b0;
    if (acc && rd != 0) m_busy[rd] = 1'b1;
    if (fl)        m_out_valid = 1'b0;
    else if (acc)  m_out_valid = 1'b1;
    else if (ordy) m_out_valid = 1'b0;
    if (acc) m_out_rd = rd;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever execute sees against the oldest expected transaction.
  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_txn: unexpected instr 0x%0h with empty scoreboard", bus.out_instr);
      end else if (bus.flush) begin
        void'(exp_q.pop_front());
      end else begin
        n_tests++;
        if (bus.out_instr !== exp_q[0].instr || bus.out_op1 !== exp_q[0].op1 ||
            bus.out_op2 !== exp_q[0].op2 || bus.out_rd !== exp_q[0].rd) begin
          n_fail++;
          $display("FAIL out_txn: got instr=%h op1=%h op2=%h rd=%0d, expected instr=%h op1=%h op2=%h rd=%0d",
                   bus.out_instr, bus.out_op1, bus.out_op2, bus.out_rd,
                   exp_q[0].instr, exp_q[0].op1, exp_q[0].op2, exp_q[0].rd);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  logic [6:0] opc_tab [11];
  reg_idx_t   busy_list[$];

  initial begin
    instr_t   ins;
    reg_idx_t wr;
    bit       wv;
    opc_tab = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                OPC_STORE, OPC_OPIMM, OPC_OP, 7'b0001111, 7'b1110011};
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_instr", bus.out_instr, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // RAW stall on x5 until its writeback, which is also bypassed into both operands
    step(1, enc_i(OPC_OPIMM, 5, 0, 12'd7), 1, 0, 0, 0, 0);
    step(1, enc_r(OPC_OP, 6, 5, 5), 1, 0, 0, 0, 0);
    step(1, enc_r(OPC_OP, 6, 5, 5), 1, 0, 0, 0, 0);
    step(1, enc_r(OPC_OP, 6, 5, 5), 1, 1, 5, 32'h7, 0);
    check("bypass_op1", bus.out_op1, 32'h7);
    check("bypass_op2", bus.out_op2, 32'h7);

    // Backpressure: held payload stays put, nothing new is taken
    step(1, enc_i(OPC_OPIMM, 7, 0, 12'd1), 0, 0, 0, 0, 0);
    step(1, enc_i(OPC_OPIMM, 7, 0, 12'd1), 0, 0, 0, 0, 0);
    check("held_instr", bus.out_instr, enc_r(OPC_OP, 6, 5, 5));
    check("held_op1",   bus.out_op1, 32'h7);
    step(1, enc_i(OPC_OPIMM, 7, 0, 12'd1), 1, 1, 6, 32'h66, 0);

    // WAW on x3, then simultaneous clear and re-set of x3 keeps it busy
    step(1, enc_i(OPC_LOAD, 3, 1, 12'd0), 1, 1, 7, 32'h1, 0);
    step(1, enc_i(OPC_LUI, 3, 0, 12'h123), 1, 0, 0, 0, 0);
    step(1, enc_i(OPC_OPIMM, 3, 0, 12'd5), 1, 1, 3, 32'h33, 0);
    step(1, enc_i(OPC_LUI, 3, 0, 12'h123), 1, 0, 0, 0, 0);
    step(0, '0, 1, 1, 3, 32'h35, 0);

    // Flush of a held ADDI x4 releases x4; x0 operands never stall
    step(1, enc_i(OPC_OPIMM, 4, 0, 12'd9), 0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 1);
    step(1, enc_i(OPC_OPIMM, 8, 4, 12'd0), 1, 0, 0, 0, 0);
    step(1, enc_r(OPC_OP, 1, 0, 0), 1, 1, 8, 32'h8, 0);
    step(1, enc_r(OPC_OP, 0, 0, 0), 1, 1, 1, 32'h11, 0);
    step(1, enc_r(OPC_OP, 0, 0, 0), 1, 0, 0, 0, 0);

    // Asynchronous reset with an instruction held
    step(1, enc_i(OPC_OPIMM, 2, 0, 12'd3), 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'd0);
    check("rst_out_op1",   bus.out_op1, 32'd0);
    check("rst_out_rd",    32'(bus.out_rd), 32'd0);
    m_busy      = '0;
    m_out_valid = 1'b0;
    m_out_rd    = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, enc_i(OPC_OPIMM, 2, 2, 12'd1), 1, 0, 0, 0, 0);

    // Randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 2000; c++) begin
      ins = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             3'($urandom), 5'($urandom_range(0, 7)), opc_tab[$urandom_range(0, 10)]};
      busy_list.delete();
      for (int r = 1; r < 8; r++) if (m_busy[r]) busy_list.push_back(5'(r));
      wv = 1'b0;
      wr = '0;
      if (busy_list.size() != 0 && $urandom_range(0, 9) < 4) begin
        wv = 1'b1;
        wr = busy_list[$urandom_range(0, busy_list.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        wv = 1'b1;
        wr = 5'($urandom_range(0, 7));
      end
      step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) < 7, wv, wr, $urandom,
           $urandom_range(0, 19) == 0);
    end

    // Drain
    for (int c = 0; c < 4; c++) step(0, '0, 1, 0, 0, 0, 0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
